// File: rtl/cal_inverse_seq_pkg.sv
// Shared constants, slot indices and FSM state type for the 4-way Karatsuba product sequencer.
package cal_inverse_seq_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 72;
  localparam int unsigned KO_PARAMETER_DEF = 4;
  localparam int unsigned NUM_SLOTS        = 9;
  localparam int unsigned STEP_W           = 4;

  // Step index == slot index; the step counter walks these in order.
  localparam int unsigned SLOT_P0    = 0;
  localparam int unsigned SLOT_P1    = 1;
  localparam int unsigned SLOT_P2    = 2;
  localparam int unsigned SLOT_P3    = 3;
  localparam int unsigned SLOT_P01   = 4;
  localparam int unsigned SLOT_P02   = 5;
  localparam int unsigned SLOT_P13   = 6;
  localparam int unsigned SLOT_P23   = 7;
  localparam int unsigned SLOT_P0123 = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cal_inverse_seq_ko4_mul_unit.sv
// Combinational step-indexed operand mux, pre-adders and single shared multiplier.
module ko4_mul_unit
  import cal_inverse_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned W          = DATA_WIDTH / KO_PARAMETER_DEF,
  parameter int unsigned PW         = 2 * W + 5
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [STEP_W-1:0]     step,
  output logic [PW-1:0]         prod_c
);

  localparam int unsigned OW = W + 2;

  logic [OW-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [OW-1:0] op_a, op_b;

  assign a0 = OW'(a[0*W +: W]);
  assign a1 = OW'(a[1*W +: W]);
  assign a2 = OW'(a[2*W +: W]);
  assign a3 = OW'(a[3*W +: W]);
  assign b0 = OW'(b[0*W +: W]);
  assign b1 = OW'(b[1*W +: W]);
  assign b2 = OW'(b[2*W +: W]);
  assign b3 = OW'(b[3*W +: W]);

  // Operands are pre-extended to W+2 bits so pair and quad sums never truncate.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (step)
      STEP_W'(SLOT_P0):    begin op_a = a0;                op_b = b0;                end
      STEP_W'(SLOT_P1):    begin op_a = a1;                op_b = b1;                end
      STEP_W'(SLOT_P2):    begin op_a = a2;                op_b = b2;                end
      STEP_W'(SLOT_P3):    begin op_a = a3;                op_b = b3;                end
      STEP_W'(SLOT_P01):   begin op_a = a0 + a1;           op_b = b0 + b1;           end
      STEP_W'(SLOT_P02):   begin op_a = a0 + a2;           op_b = b0 + b2;           end
      STEP_W'(SLOT_P13):   begin op_a = a1 + a3;           op_b = b1 + b3;           end
      STEP_W'(SLOT_P23):   begin op_a = a2 + a3;           op_b = b2 + b3;           end
      STEP_W'(SLOT_P0123): begin op_a = a0 + a1 + a2 + a3; op_b = b0 + b1 + b2 + b3; end
      default:             begin op_a = '0;                op_b = '0;                end
    endcase
  end

  assign prod_c = PW'(op_a) * PW'(op_b);

endmodule

// File: rtl/cal_inverse_seq.sv
// Sequential 4-way Karatsuba partial-product generator: one slot per cycle, with optional inverted copy.
module cal_inverse_seq
  import cal_inverse_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned KO_PARAMETER = KO_PARAMETER_DEF,
  parameter bit          INV_EN       = 1'b1,
  localparam int unsigned W  = DATA_WIDTH / KO_PARAMETER,
  localparam int unsigned PW = 2 * W + 5,
  localparam int unsigned PT = NUM_SLOTS * PW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PT-1:0]         prod,
  output logic [PT-1:0]         prod_i,
  output logic                  busy
);

  if (KO_PARAMETER != 4) begin : g_bad_ko
    $error("cal_inverse_seq: KO_PARAMETER must be 4");
  end
  if ((DATA_WIDTH % KO_PARAMETER) != 0) begin : g_bad_dw
    $error("cal_inverse_seq: DATA_WIDTH must be divisible by KO_PARAMETER");
  end

  state_e                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PT-1:0]         prod_q, prod_d, prod_i_q, prod_i_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [PW-1:0]         mul_c;

  ko4_mul_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .W          (W),
    .PW         (PW)
  ) u_mul (
    .a      (a_q),
    .b      (b_q),
    .step   (step_q),
    .prod_c (mul_c)
  );

  // Next-state, operand capture and slot write-back.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          step_d  = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        for (int k = 0; k < int'(NUM_SLOTS); k++) begin
          if (step_q == STEP_W'(k)) prod_d[k*PW +: PW] = mul_c;
        end
        if (step_q == STEP_W'(NUM_SLOTS - 1)) begin
          step_d  = '0;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    prod_i_d    = INV_EN ? ~prod_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      prod_i_q    <= INV_EN ? '1 : '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      prod_i_q    <= prod_i_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign prod      = prod_q;
  assign prod_i    = prod_i_q;

endmodule

// File: tb/tb_cal_inverse_seq.sv
// Randomized self-checking bench for cal_inverse_seq against an arithmetic slot model.
module tb_cal_inverse_seq;

  localparam int unsigned DW = 72;
  localparam int unsigned W  = 18;
  localparam int unsigned PW = 41;
  localparam int unsigned PT = 9 * PW;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready;
  logic [DW-1:0] a, b;
  logic          in_ready, out_valid, busy;
  logic [PT-1:0] prod, prod_i;
  logic          in_ready_n, out_valid_n, busy_n;
  logic [PT-1:0] prod_n, prod_i_n;

  int n_cmp = 0;
  int n_err = 0;

  cal_inverse_seq #(.DATA_WIDTH(72), .KO_PARAMETER(4), .INV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .prod_i(prod_i), .busy(busy)
  );

  cal_inverse_seq #(.DATA_WIDTH(72), .KO_PARAMETER(4), .INV_EN(1'b0)) dut_ni (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .a(a), .b(b),
    .out_valid(out_valid_n), .out_ready(out_ready), .prod(prod_n), .prod_i(prod_i_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  function automatic logic [PT-1:0] ref_prod(input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint unsigned xa[4];
    longint unsigned yb[4];
    longint unsigned s[9];
    logic [PT-1:0]   r;
    for (int i = 0; i < 4; i++) begin
      xa[i] = x[i*W +: W];
      yb[i] = y[i*W +: W];
      s[i]  = xa[i] * yb[i];
    end
    s[4] = (xa[0] + xa[1]) * (yb[0] + yb[1]);
    s[5] = (xa[0] + xa[2]) * (yb[0] + yb[2]);
    s[6] = (xa[1] + xa[3]) * (yb[1] + yb[3]);
    s[7] = (xa[2] + xa[3]) * (yb[2] + yb[3]);
    s[8] = (xa[0] + xa[1] + xa[2] + xa[3]) * (yb[0] + yb[1] + yb[2] + yb[3]);
    r = '0;
    for (int k = 0; k < 9; k++) r[k*PW +: PW] = s[k][PW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_op();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and count edges from acceptance to out_valid (-1 on timeout).
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_flags out_valid=%b busy=%b exp=0/0", out_valid, busy); end
    n_cmp++; if (prod !== '0) begin n_err++; $display("FAIL reset_prod got=%h exp=0", prod); end
    n_cmp++; if (prod_i !== {PT{1'b1}}) begin n_err++; $display("FAIL reset_prod_i got=%h exp=all-ones", prod_i); end
    n_cmp++; if (prod_i_n !== '0) begin n_err++; $display("FAIL reset_prod_i_noinv got=%h exp=0", prod_i_n); end
  endtask

  task automatic test_directed();
    logic [DW-1:0]  x, y;
    logic [PW-1:0]  exp_slot[9];
    int             lat;
    exp_slot = '{41'd3, 41'd10, 41'd21, 41'd44, 41'd24, 41'd40, 41'd96, 41'd126, 41'd260};
    x = {18'd11, 18'd7, 18'd5, 18'd3};
    y = {18'd4, 18'd3, 18'd2, 18'd1};
    send(x, y, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL directed_latency got=%0d exp=9", lat); end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (prod[k*PW +: PW] !== exp_slot[k]) begin
        n_err++; $display("FAIL directed_slot%0d got=%0d exp=%0d", k, prod[k*PW +: PW], exp_slot[k]);
      end
    end
    n_cmp++; if (prod_i !== ~ref_prod(x, y)) begin n_err++; $display("FAIL directed_prod_i got=%h exp=%h", prod_i, ~ref_prod(x, y)); end
    n_cmp++; if (prod_n !== ref_prod(x, y)) begin n_err++; $display("FAIL directed_noinv_prod got=%h exp=%h", prod_n, ref_prod(x, y)); end
    n_cmp++; if (prod_i_n !== '0) begin n_err++; $display("FAIL directed_noinv_prod_i got=%h exp=0", prod_i_n); end
    release_out();
  endtask

  task automatic test_all_ones();
    int lat;
    send({DW{1'b1}}, {DW{1'b1}}, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL ones_latency got=%0d exp=9", lat); end
    n_cmp++; if (prod[0*PW +: PW] !== 41'd68718952449) begin n_err++; $display("FAIL ones_slot0 got=%0d exp=68718952449", prod[0*PW +: PW]); end
    n_cmp++; if (prod[4*PW +: PW] !== 41'd274875809796) begin n_err++; $display("FAIL ones_slot4 got=%0d exp=274875809796", prod[4*PW +: PW]); end
    n_cmp++; if (prod[8*PW +: PW] !== 41'd1099503239184) begin n_err++; $display("FAIL ones_slot8 got=%0d exp=1099503239184", prod[8*PW +: PW]); end
    n_cmp++; if (prod_i[0*PW +: PW] !== 41'd2130304303102) begin n_err++; $display("FAIL ones_prod_i_slot0 got=%0d exp=2130304303102", prod_i[0*PW +: PW]); end
    release_out();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ones_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] x, y;
    logic [PT-1:0] exp_p;
    int            lat;
    x = rand_op(); y = rand_op();
    exp_p = ref_prod(x, y);
    send(x, y, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL stall_latency got=%0d exp=9", lat); end
    for (int c = 0; c < 5; c++) begin
      a = rand_op(); b = rand_op(); in_valid = 1'($urandom_range(0, 1));
      tick();
      n_cmp++; if (prod !== exp_p || prod_i !== ~exp_p) begin n_err++; $display("FAIL stall_hold_c%0d got=%h exp=%h", c, prod, exp_p); end
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_flags_c%0d in_ready=%b out_valid=%b exp=0/1", c, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    release_out();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_calc();
    logic [DW-1:0] x, y;
    int            lat;
    a = rand_op(); b = rand_op(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_flags in_ready=%b out_valid=%b busy=%b exp=1/0/0", in_ready, out_valid, busy);
    end
    n_cmp++; if (prod !== '0 || prod_i !== {PT{1'b1}}) begin n_err++; $display("FAIL midrst_prod got=%h exp=0", prod); end
    x = rand_op(); y = rand_op();
    send(x, y, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL midrst_latency got=%0d exp=9", lat); end
    n_cmp++; if (prod !== ref_prod(x, y)) begin n_err++; $display("FAIL midrst_fresh got=%h exp=%h", prod, ref_prod(x, y)); end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] q[$];
    logic [2*DW-1:0] e;
    logic            acc, hs;
    int              last_acc, n_acc;
    last_acc = -1; n_acc = 0;
    a = rand_op(); b = rand_op(); in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      acc = in_ready; hs = out_valid;
      if (hs) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL b2b_unexpected_result cyc=%0d got=%h exp=none", cyc, prod); end
        else begin
          e = q.pop_front();
          if (prod !== ref_prod(e[2*DW-1:DW], e[DW-1:0])) begin
            n_err++; $display("FAIL b2b_result cyc=%0d got=%h exp=%h", cyc, prod, ref_prod(e[2*DW-1:DW], e[DW-1:0]));
          end
        end
      end
      if (acc) q.push_back({a, b});
      tick();
      if (acc) begin
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc !== 11) begin n_err++; $display("FAIL b2b_interval got=%0d exp=11", cyc - last_acc); end
        end
        last_acc = cyc; n_acc++;
        a = rand_op(); b = rand_op();
      end
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL b2b_drain_unexpected got=%h exp=none", prod); end
        else begin
          e = q.pop_front();
          if (prod !== ref_prod(e[2*DW-1:DW], e[DW-1:0])) begin
            n_err++; $display("FAIL b2b_drain got=%h exp=%h", prod, ref_prod(e[2*DW-1:DW], e[DW-1:0]));
          end
        end
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL b2b_lost got=%0d exp=0 pending", q.size()); end
    n_cmp++; if (n_acc < 6) begin n_err++; $display("FAIL b2b_accepts got=%0d exp>=6", n_acc); end
  endtask

  task automatic test_random();
    logic [DW-1:0] x, y;
    int            lat, stall;
    for (int t = 0; t < 6; t++) begin
      x = rand_op(); y = rand_op();
      send(x, y, lat);
      n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL rand%0d_latency got=%0d exp=9", t, lat); end
      stall = $urandom_range(0, 3);
      for (int c = 0; c < stall; c++) tick();
      n_cmp++; if (prod !== ref_prod(x, y) || prod_n !== ref_prod(x, y)) begin
        n_err++; $display("FAIL rand%0d_prod got=%h exp=%h", t, prod, ref_prod(x, y));
      end
      n_cmp++; if (prod_i !== ~ref_prod(x, y) || prod_i_n !== '0) begin
        n_err++; $display("FAIL rand%0d_prod_i got=%h exp=%h", t, prod_i, ~ref_prod(x, y));
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_all_ones();
    test_stall();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
